bcd_operand_loader: RTL
=======================

Name: bcd_operand_loader

Overview:
Upstream operand-entry stage for the two-digit BCD adder datapath. The user enters operand A and then operand B on one 8-bit switch bank. Each entry is committed by a pushbutton press, which the block synchronizes and debounces. Captured digits are held stable on registered outputs that feed the adder's A1/A0/B1/B0 inputs directly, with Valid and Err status for green LEDs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles of synchronized key level needed to accept a change (10 ms at 50 MHz); minimum 1.
CNT_W, 19, width of debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
Clock  input  1  system clock, rising-edge.
Resetn  input  1  asynchronous active-low reset.
Din  input  8  raw switch value; Din[7:4] = tens digit, Din[3:0] = units digit.
LoadKey  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to Clock.
A1  output  4  operand A tens digit (registered).
A0  output  4  operand A units digit (registered).
B1  output  4  operand B tens digit (registered).
B0  output  4  operand B units digit (registered).
Valid  output  1  high while both operands are captured and stable.
Err  output  1  high after a rejected entry; cleared by the next accepted entry.
State  output  2  current FSM state encoding, for LED display.

Behaviour:
- Reset (Resetn = 0, asynchronous): A1 = A0 = B1 = B0 = 0; Valid = 0; Err = 0; State = GET_A (2'b00).
- Reset forces the debounced key level to released (1), clears the debounce counter, and presets both sync flops to 1.
- Reset mid-entry discards any partially captured operands.
- Sync: LoadKey passes through a 2-flop synchronizer.
- Debounce:
  - When the synchronized level differs from the debounced level, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level updates and the counter clears.
  - Any cycle where the levels match clears the counter.
- Press pulse: a 1-cycle pulse on the debounced 1->0 transition. Release never generates a pulse. Holding the key yields exactly one pulse.
- Latency: a clean press is first sampled on cycle 0 and produces the pulse on cycle 2+DEBOUNCE_CYCLES. Outputs and State update on the following edge.
- Digit check: an entry is valid when Din[7:4] <= 9 and Din[3:0] <= 9. Din is sampled only in the pulse cycle.
- FSM states:
  - GET_A (00): on pulse with valid Din, load A1/A0 from Din, Err = 0, go to GET_B. On pulse with invalid Din, Err = 1, A unchanged, stay.
  - GET_B (01): on pulse with valid Din, load B1/B0, Err = 0, Valid = 1, go to READY. On pulse with invalid Din, Err = 1, stay.
  - READY (10): Valid = 1, operands frozen. On pulse with valid Din, load A1/A0, clear B1/B0 to 0, Valid = 0, Err = 0, go to GET_B. On pulse with invalid Din, Err = 1, Valid stays 1, operands unchanged, stay.
  - State 11 is unreachable; if entered, go to GET_A on the next edge with all outputs as at reset.
- Valid is registered and changes on the same edge as the operand registers. The downstream adder never sees mixed old/new operands while Valid = 1.
- Din changing while no pulse is present has no effect.
- A key bounce shorter than DEBOUNCE_CYCLES produces no pulse.

Optional Feature:
- Macro: OPERAND_CLAMP_EN.
- Defined: an invalid digit is not rejected. Each nibble greater than 9 is clamped to 9 before capture, the FSM advances as for a valid entry, and Err is set to 1 for that entry (cleared by the next entry with no clamping).
- Undefined: reject behaviour as specified above; no clamp logic is synthesized.

Test Plan:
- Reset then idle, DEBOUNCE_CYCLES = 4 -> all digits 0, Valid = 0, Err = 0, State = 00.
- Din = 8'h47, clean press; Din = 8'h58, clean press -> A1/A0 = 4/7, then B1/B0 = 5/8, Valid = 1, State = 10. The pulse appears exactly 6 cycles after the first sampled low.
- Din = 8'h3A press in GET_A -> Err = 1, A = 0/0, State = 00. Then Din = 8'h12 press -> A = 1/2, Err = 0, State = 01.
- Bounce LoadKey low for 3 cycles, high 2, then low steadily (DEBOUNCE_CYCLES = 4) -> exactly one pulse. Holding low 100 cycles -> no further capture.
- In READY with A = 99, B = 99: press with Din = 8'h05 -> A = 0/5, B = 0/0, Valid = 0, State = 01. Assert Resetn = 0 mid-debounce -> immediate reset values, no pulse after release of reset.
- With OPERAND_CLAMP_EN defined, Din = 8'hFB in GET_A -> A = 9/9, Err = 1, State = 01.

Source files
------------

// File: rtl/bcd_operand_loader.sv
// Operand-entry stage for the two-digit BCD adder: a synchronized, debounced load key captures A then B from Din.
// Optional macro OPERAND_CLAMP_EN: out-of-range nibbles are clamped to 9 and flagged instead of rejected.
module bcd_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] Din,
  input  logic       LoadKey,
  output logic [3:0] A1,
  output logic [3:0] A0,
  output logic [3:0] B1,
  output logic [3:0] B0,
  output logic       Valid,
  output logic       Err,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    READY = 2'b10,
    BAD   = 2'b11
  } state_t;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  state_t           state_q, state_d;
  logic [3:0]       a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;
  logic             valid_q, valid_d, err_q, err_d;

  logic [3:0]       tens, units;
  logic             entry_ok, entry_err;

`ifdef OPERAND_CLAMP_EN
  assign tens      = (Din[7:4] > 4'd9) ? 4'd9 : Din[7:4];
  assign units     = (Din[3:0] > 4'd9) ? 4'd9 : Din[3:0];
  assign entry_ok  = 1'b1;
  assign entry_err = (Din[7:4] > 4'd9) || (Din[3:0] > 4'd9);
`else
  assign tens      = Din[7:4];
  assign units     = Din[3:0];
  assign entry_ok  = (Din[7:4] <= 4'd9) && (Din[3:0] <= 4'd9);
  assign entry_err = 1'b0;
`endif

  // Debounce: the level must differ for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulse_d = deb_prev_q & ~deb_q;
  end

  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      GET_A: begin
        if (pulse_q) begin
          if (entry_ok) begin
            a1_d    = tens;
            a0_d    = units;
            err_d   = entry_err;
            state_d = GET_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_B: begin
        if (pulse_q) begin
          if (entry_ok) begin
            b1_d    = tens;
            b0_d    = units;
            valid_d = 1'b1;
            err_d   = entry_err;
            state_d = READY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READY: begin
        // A new valid entry starts a fresh pair; B is cleared so no stale operand survives.
        if (pulse_q) begin
          if (entry_ok) begin
            a1_d    = tens;
            a0_d    = units;
            b1_d    = 4'd0;
            b0_d    = 4'd0;
            valid_d = 1'b0;
            err_d   = entry_err;
            state_d = GET_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = GET_A;
        a1_d    = 4'd0;
        a0_d    = 4'd0;
        b1_d    = 4'd0;
        b0_d    = 4'd0;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      state_q    <= GET_A;
      a1_q       <= 4'd0;
      a0_q       <= 4'd0;
      b1_q       <= 4'd0;
      b0_q       <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= LoadKey;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      state_q    <= state_d;
      a1_q       <= a1_d;
      a0_q       <= a0_d;
      b1_q       <= b1_d;
      b0_q       <= b0_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign A1    = a1_q;
  assign A0    = a0_q;
  assign B1    = b1_q;
  assign B0    = b0_q;
  assign Valid = valid_q;
  assign Err   = err_q;
  assign State = state_q;

endmodule
